// File: rtl/interleaver_pkg.sv
// Shared constants and index arithmetic for the 802.11a transmit block interleaver.
// Latency: n/a (package only; functions are pure combinational helpers).
// Backpressure: n/a.
//
// Contents: default configuration, beat/counter sizing helpers, and the two-step
// interleaver permutation that maps in-symbol bit index k to bank position j.
package interleaver_pkg;

  localparam int DEF_N_BPSC = 1;
  localparam int DEF_N_CBPS = 48;
  localparam int BEATS      = DEF_N_CBPS / 2;
  localparam int CNT_W      = $clog2(BEATS);

  // Rotation group size of the second permutation step.
  function automatic int unsigned s_of(input int unsigned n_bpsc);
    return (n_bpsc / 2 > 1) ? n_bpsc / 2 : 1;
  endfunction

  function automatic int unsigned beats_of(input int unsigned n_cbps);
    return n_cbps / 2;
  endfunction

  function automatic int unsigned cnt_w_of(input int unsigned n_cbps);
    return $clog2(n_cbps / 2);
  endfunction

  // Two-step permutation. All terms stay non-negative and well inside 32 bits,
  // so nothing is truncated before the final modulo.
  function automatic int unsigned perm_index(input int unsigned k,
                                             input int unsigned n_cbps,
                                             input int unsigned n_bpsc);
    int unsigned s;
    int unsigned i;
    s = s_of(n_bpsc);
    i = (n_cbps / 16) * (k % 16) + k / 16;
    return s * (i / s) + (i + n_cbps - (16 * i) / n_cbps) % s;
  endfunction

endpackage

// File: rtl/interleaver_bank.sv
// One symbol of interleaver storage: scattered 2-bit write, sequential 2-bit read.
// Latency: write visible the cycle after wr_en; read is combinational from storage.
// Backpressure: none; the parent only writes a bank that is not full.
//
// Ports: clk; wr_en/wr_addr0/wr_addr1/wr_data write bit0 to addr0 and bit1 to addr1;
// rd_beat selects positions 2*rd_beat and 2*rd_beat+1 returned on rd_data[0]/[1].
module interleaver_bank
  import interleaver_pkg::*;
#(
  parameter int N_CBPS = DEF_N_CBPS
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [$clog2(N_CBPS)-1:0]   wr_addr0,
  input  logic [$clog2(N_CBPS)-1:0]   wr_addr1,
  input  logic [1:0]                  wr_data,
  input  logic [$clog2(N_CBPS)-2:0]   rd_beat,
  output logic [1:0]                  rd_data
);

  localparam int AW = $clog2(N_CBPS);

  logic [N_CBPS-1:0] mem_q;
  logic [N_CBPS-1:0] mem_d;
  logic [AW-1:0]     rd_addr0;
  logic [AW-1:0]     rd_addr1;

  assign rd_addr0 = {rd_beat, 1'b0};
  assign rd_addr1 = {rd_beat, 1'b1};

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr0] = wr_data[0];
      mem_d[wr_addr1] = wr_data[1];
    end
  end

  // Contents are meaningless until a full symbol has been written, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = {mem_q[rd_addr1], mem_q[rd_addr0]};

endmodule

// File: rtl/interleaver_stream.sv
// 802.11a TX block interleaver, 2 bits/cycle in and out, ping-pong symbol banks.
// Latency: first output beat valid the cycle after the last input beat of a symbol.
// Backpressure: in_ready drops while both banks are full; outputs hold while !out_ready.
//
// Ports: clk, rst_n (async, active-low); in_data/in_valid/in_ready coded-bit input
// ([0] = bit k, [1] = bit k+1); out_data/out_valid/out_ready interleaved output
// ([0] = position 2m, [1] = 2m+1); out_sos/out_eos mark first/last beat of a symbol.
module interleaver_stream
  import interleaver_pkg::*;
#(
  parameter int N_BPSC = DEF_N_BPSC,
  parameter int N_CBPS = DEF_N_CBPS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sos,
  output logic       out_eos
);

  localparam int AW     = $clog2(N_CBPS);
  localparam int CW     = cnt_w_of(N_CBPS);
  localparam int NBEATS = beats_of(N_CBPS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

  logic [1:0]    full_q,   full_d;
  logic          wr_sel_q, wr_sel_d;
  logic          rd_sel_q, rd_sel_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;

  logic          in_acc;
  logic          out_acc;
  logic          wr_last;
  logic          rd_last;
  logic [AW-1:0] k0;
  logic [AW-1:0] wa0;
  logic [AW-1:0] wa1;
  logic [1:0]    bank_we;
  logic [1:0]    bank_rd [2];

  // Flags are registered, so a bank freed this cycle only shows up as ready next cycle.
  assign in_ready  = !full_q[wr_sel_q];
  assign out_valid = full_q[rd_sel_q];
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;
  assign wr_last   = (wr_cnt_q == LAST_BEAT);
  assign rd_last   = (rd_cnt_q == LAST_BEAT);

  // Bit index of in_data[0] within the symbol being filled.
  assign k0 = {wr_cnt_q, 1'b0};

  always_comb begin
    wa0 = AW'(perm_index(32'(k0), N_CBPS, N_BPSC));
    wa1 = AW'(perm_index(32'(k0) + 32'd1, N_CBPS, N_BPSC));
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b] = in_acc && (wr_sel_q == 1'(b));

    interleaver_bank #(
      .N_CBPS (N_CBPS)
    ) u_bank (
      .clk      (clk),
      .wr_en    (bank_we[b]),
      .wr_addr0 (wa0),
      .wr_addr1 (wa1),
      .wr_data  (in_data),
      .rd_beat  (rd_cnt_q),
      .rd_data  (bank_rd[b])
    );
  end

  // Outputs derive only from flops, so they are stable for the whole stall.
  always_comb begin
    out_data = 2'b00;
    out_sos  = 1'b0;
    out_eos  = 1'b0;
    if (out_valid) begin
      out_data = bank_rd[rd_sel_q];
      out_sos  = (rd_cnt_q == '0);
      out_eos  = rd_last;
    end
  end

  // A completing write and a completing read always touch different banks
  // (one must be empty, the other full), so both flag updates can apply.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (in_acc) begin
      if (wr_last) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = !wr_sel_q;
        wr_cnt_d         = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + CW'(1);
      end
    end
    if (out_acc) begin
      if (rd_last) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = !rd_sel_q;
        rd_cnt_d         = '0;
      end else begin
        rd_cnt_d = rd_cnt_q + CW'(1);
      end
    end
  end

  // Reset drops any partially written symbol by clearing counters and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q   <= 2'b00;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

endmodule
